// File: rtl/dff_checker.sv
// Response checker for a D flip-flop / short register pipeline: confirms q_in
// reproduces d_in exactly LATENCY clocks later and reports a registered verdict.
module dff_checker #(
  parameter int LATENCY    = 1,
  parameter int NUM_CHECKS = 16,
  parameter int CW         = 8,
  parameter int IW         = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          d_in,
  input  logic          q_in,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic          fail,
  output logic [CW-1:0] err_count,
  output logic          err_seen,
  output logic [IW-1:0] first_err_idx
);

  typedef enum logic [1:0] {IDLE, WARM, CHECK, DONE} state_t;

  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_CHECKS - 1);
  localparam logic [CW-1:0] CNT_MAX   = '1;
  localparam logic [3:0]    WARM_LOAD = 4'(LATENCY - 1);

  state_t              state, state_nxt;
  logic [LATENCY-1:0]  dly;
  logic [3:0]          wcnt;
  logic [IW-1:0]       idx;
  logic                exp_bit, mism, accept, last_chk, err_nz;

  assign exp_bit  = dly[LATENCY-1];
  // !== so an X/Z on q_in is flagged rather than silently matching
  assign mism     = (state == CHECK) && (q_in !== exp_bit);
  assign accept   = start && ((state == IDLE) || (state == DONE));
  assign last_chk = (idx == LAST_IDX);
  assign err_nz   = (err_count != '0) || mism;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = WARM;
      WARM:    if (wcnt == 4'd0) state_nxt = CHECK;
      CHECK:   if (last_chk) state_nxt = DONE;
      DONE:    if (start) state_nxt = WARM;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Runs in every state so pre-start history is flushed during WARM.
  always_ff @(posedge clk) begin
    if (reset) begin
      dly <= '0;
    end else begin
      dly[0] <= d_in;
      for (int i = 1; i < LATENCY; i++) dly[i] <= dly[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      fail          <= 1'b0;
      err_count     <= '0;
      err_seen      <= 1'b0;
      first_err_idx <= '0;
      idx           <= '0;
      wcnt          <= '0;
    end else begin
      busy <= (state_nxt == WARM) || (state_nxt == CHECK);
      done <= (state_nxt == DONE);
      if (accept) begin
        pass          <= 1'b0;
        fail          <= 1'b0;
        err_count     <= '0;
        err_seen      <= 1'b0;
        first_err_idx <= '0;
        idx           <= '0;
        wcnt          <= WARM_LOAD;
      end else if (state == WARM) begin
        if (wcnt != 4'd0) wcnt <= wcnt - 4'(1);
      end else if (state == CHECK) begin
        if (mism) begin
          if (err_count != CNT_MAX) err_count <= err_count + CW'(1);
          if (!err_seen) begin
            err_seen      <= 1'b1;
            first_err_idx <= idx;
          end
        end
        // Verdict folds in the final compare, which lands on this same edge.
        if (last_chk) begin
          pass <= !err_nz;
          fail <= err_nz;
        end else begin
          idx <= idx + IW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_dff_checker.sv
// Directed bench: ideal, faulted, latency-mismatched and saturating checkers
// share one stimulus stream; d_in toggles every cycle.
module tb_dff_checker;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic d_in = 1'b0;
  logic q_dff = 1'b0;
  logic flt = 1'b0;
  logic q0, q2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) q_dff <= d_in;
  assign q0 = q_dff ^ flt;
  assign q2 = ~q_dff;

  logic       busy0, done0, pass0, fail0, seen0;
  logic [7:0] cnt0, fidx0;
  logic       busy1, done1, pass1, fail1, seen1;
  logic [7:0] cnt1, fidx1;
  logic       busy2, done2, pass2, fail2, seen2;
  logic [2:0] cnt2;
  logic [7:0] fidx2;

  dff_checker #(.LATENCY(1), .NUM_CHECKS(16), .CW(8), .IW(8)) u_dut (
    .clk(clk), .reset(reset), .start(start), .d_in(d_in), .q_in(q0),
    .busy(busy0), .done(done0), .pass(pass0), .fail(fail0),
    .err_count(cnt0), .err_seen(seen0), .first_err_idx(fidx0));

  dff_checker #(.LATENCY(2), .NUM_CHECKS(16), .CW(8), .IW(8)) u_lat2 (
    .clk(clk), .reset(reset), .start(start), .d_in(d_in), .q_in(q_dff),
    .busy(busy1), .done(done1), .pass(pass1), .fail(fail1),
    .err_count(cnt1), .err_seen(seen1), .first_err_idx(fidx1));

  dff_checker #(.LATENCY(1), .NUM_CHECKS(16), .CW(3), .IW(8)) u_sat (
    .clk(clk), .reset(reset), .start(start), .d_in(d_in), .q_in(q2),
    .busy(busy2), .done(done2), .pass(pass2), .fail(fail2),
    .err_count(cnt2), .err_seen(seen2), .first_err_idx(fidx2));

  // One clock: drive, take the rising edge, return at the falling edge.
  task automatic tick(input logic st, input logic f);
    start = st;
    flt   = f;
    @(posedge clk);
    @(negedge clk);
    d_in  = ~d_in;
    start = 1'b0;
    flt   = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    reset = 1'b0;
    checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL rst_busy got=%0b exp=0", busy0); end
    checks++; if (done0 !== 1'b0) begin failures++; $display("FAIL rst_done got=%0b exp=0", done0); end
    checks++; if (pass0 !== 1'b0) begin failures++; $display("FAIL rst_pass got=%0b exp=0", pass0); end
    checks++; if (fail0 !== 1'b0) begin failures++; $display("FAIL rst_fail got=%0b exp=0", fail0); end
    checks++; if (cnt0 !== 8'd0) begin failures++; $display("FAIL rst_cnt got=%0d exp=0", cnt0); end
    checks++; if (seen0 !== 1'b0) begin failures++; $display("FAIL rst_seen got=%0b exp=0", seen0); end
    checks++; if (fidx0 !== 8'd0) begin failures++; $display("FAIL rst_fidx got=%0d exp=0", fidx0); end
  endtask

  task automatic test_ideal;
    tick(1'b1, 1'b0);
    checks++; if (busy0 !== 1'b1) begin failures++; $display("FAIL ideal_busy_e0 got=%0b exp=1", busy0); end
    for (int j = 1; j <= 18; j++) begin
      tick(1'b0, 1'b0);
      if (j == 7) begin
        checks++; if (cnt2 !== 3'd6) begin failures++; $display("FAIL sat_cnt_e7 got=%0d exp=6", cnt2); end
      end
      if (j == 10) begin
        checks++; if (cnt2 !== 3'd7) begin failures++; $display("FAIL sat_cnt_e10 got=%0d exp=7", cnt2); end
      end
      if (j == 16) begin
        checks++; if (done0 !== 1'b0) begin failures++; $display("FAIL ideal_done_e16 got=%0b exp=0", done0); end
        checks++; if (busy0 !== 1'b1) begin failures++; $display("FAIL ideal_busy_e16 got=%0b exp=1", busy0); end
      end
      if (j == 17) begin
        checks++; if (done0 !== 1'b1) begin failures++; $display("FAIL ideal_done got=%0b exp=1", done0); end
        checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL ideal_busy_end got=%0b exp=0", busy0); end
        checks++; if (pass0 !== 1'b1) begin failures++; $display("FAIL ideal_pass got=%0b exp=1", pass0); end
        checks++; if (fail0 !== 1'b0) begin failures++; $display("FAIL ideal_fail got=%0b exp=0", fail0); end
        checks++; if (cnt0 !== 8'd0) begin failures++; $display("FAIL ideal_cnt got=%0d exp=0", cnt0); end
        checks++; if (seen0 !== 1'b0) begin failures++; $display("FAIL ideal_seen got=%0b exp=0", seen0); end
        checks++; if (done1 !== 1'b0) begin failures++; $display("FAIL lat2_done_e17 got=%0b exp=0", done1); end
      end
    end
    checks++; if (done1 !== 1'b1) begin failures++; $display("FAIL lat2_done got=%0b exp=1", done1); end
    checks++; if (fail1 !== 1'b1) begin failures++; $display("FAIL lat2_fail got=%0b exp=1", fail1); end
    checks++; if (cnt1 !== 8'd16) begin failures++; $display("FAIL lat2_cnt got=%0d exp=16", cnt1); end
    checks++; if (fidx1 !== 8'd0) begin failures++; $display("FAIL lat2_fidx got=%0d exp=0", fidx1); end
    checks++; if (cnt2 !== 3'd7) begin failures++; $display("FAIL sat_cnt_done got=%0d exp=7", cnt2); end
    checks++; if (fail2 !== 1'b1) begin failures++; $display("FAIL sat_fail got=%0b exp=1", fail2); end
  endtask

  task automatic test_single_fault;
    tick(1'b1, 1'b0);
    for (int j = 1; j <= 18; j++) begin
      tick(1'b0, j == 7);
      if (j == 6) begin
        checks++; if (seen0 !== 1'b0) begin failures++; $display("FAIL flt_seen_e6 got=%0b exp=0", seen0); end
      end
      if (j == 7) begin
        checks++; if (seen0 !== 1'b1) begin failures++; $display("FAIL flt_seen_e7 got=%0b exp=1", seen0); end
      end
    end
    checks++; if (fail0 !== 1'b1) begin failures++; $display("FAIL flt_fail got=%0b exp=1", fail0); end
    checks++; if (pass0 !== 1'b0) begin failures++; $display("FAIL flt_pass got=%0b exp=0", pass0); end
    checks++; if (cnt0 !== 8'd1) begin failures++; $display("FAIL flt_cnt got=%0d exp=1", cnt0); end
    checks++; if (seen0 !== 1'b1) begin failures++; $display("FAIL flt_seen got=%0b exp=1", seen0); end
    checks++; if (fidx0 !== 8'd5) begin failures++; $display("FAIL flt_fidx got=%0d exp=5", fidx0); end
  endtask

  task automatic test_start_in_check;
    tick(1'b1, 1'b0);
    for (int j = 1; j <= 18; j++) begin
      tick(j == 5, 1'b0);
      if (j == 16) begin
        checks++; if (done0 !== 1'b0) begin failures++; $display("FAIL sic_done_e16 got=%0b exp=0", done0); end
      end
      if (j == 17) begin
        checks++; if (done0 !== 1'b1) begin failures++; $display("FAIL sic_done got=%0b exp=1", done0); end
        checks++; if (pass0 !== 1'b1) begin failures++; $display("FAIL sic_pass got=%0b exp=1", pass0); end
      end
    end
  endtask

  task automatic test_reset_mid;
    tick(1'b1, 1'b0);
    for (int j = 1; j <= 4; j++) tick(1'b0, j == 3);
    checks++; if (cnt0 !== 8'd1) begin failures++; $display("FAIL mid_cnt_pre got=%0d exp=1", cnt0); end
    checks++; if (fidx0 !== 8'd1) begin failures++; $display("FAIL mid_fidx_pre got=%0d exp=1", fidx0); end
    reset = 1'b1;
    tick(1'b0, 1'b0);
    reset = 1'b0;
    checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL mid_busy got=%0b exp=0", busy0); end
    checks++; if (done0 !== 1'b0) begin failures++; $display("FAIL mid_done got=%0b exp=0", done0); end
    checks++; if (cnt0 !== 8'd0) begin failures++; $display("FAIL mid_cnt got=%0d exp=0", cnt0); end
    checks++; if (seen0 !== 1'b0) begin failures++; $display("FAIL mid_seen got=%0b exp=0", seen0); end
    for (int j = 0; j < 20; j++) tick(1'b0, 1'b0);
    checks++; if (done0 !== 1'b0) begin failures++; $display("FAIL mid_no_verdict got=%0b exp=0", done0); end
  endtask

  task automatic test_start_with_reset;
    reset = 1'b1;
    tick(1'b1, 1'b0);
    reset = 1'b0;
    checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL swr_busy got=%0b exp=0", busy0); end
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL swr_busy_later got=%0b exp=0", busy0); end
    checks++; if (done0 !== 1'b0) begin failures++; $display("FAIL swr_done got=%0b exp=0", done0); end
  endtask

  task automatic test_back_to_back;
    tick(1'b1, 1'b0);
    for (int j = 1; j <= 18; j++) tick(1'b0, (j == 2) || (j == 10));
    checks++; if (fail0 !== 1'b1) begin failures++; $display("FAIL b2b_fail1 got=%0b exp=1", fail0); end
    checks++; if (cnt0 !== 8'd2) begin failures++; $display("FAIL b2b_cnt1 got=%0d exp=2", cnt0); end
    checks++; if (fidx0 !== 8'd0) begin failures++; $display("FAIL b2b_fidx1 got=%0d exp=0", fidx0); end
    tick(1'b1, 1'b0);
    checks++; if (busy0 !== 1'b1) begin failures++; $display("FAIL b2b_busy got=%0b exp=1", busy0); end
    checks++; if (done0 !== 1'b0) begin failures++; $display("FAIL b2b_done_clr got=%0b exp=0", done0); end
    checks++; if (fail0 !== 1'b0) begin failures++; $display("FAIL b2b_fail_clr got=%0b exp=0", fail0); end
    checks++; if (cnt0 !== 8'd0) begin failures++; $display("FAIL b2b_cnt_clr got=%0d exp=0", cnt0); end
    checks++; if (seen0 !== 1'b0) begin failures++; $display("FAIL b2b_seen_clr got=%0b exp=0", seen0); end
    for (int j = 1; j <= 17; j++) begin
      tick(1'b0, 1'b0);
      if (j == 16) begin
        checks++; if (done0 !== 1'b0) begin failures++; $display("FAIL b2b_done_e16 got=%0b exp=0", done0); end
      end
    end
    checks++; if (pass0 !== 1'b1) begin failures++; $display("FAIL b2b_pass2 got=%0b exp=1", pass0); end
    checks++; if (fail0 !== 1'b0) begin failures++; $display("FAIL b2b_fail2 got=%0b exp=0", fail0); end
    checks++; if (cnt0 !== 8'd0) begin failures++; $display("FAIL b2b_cnt2 got=%0d exp=0", cnt0); end
  endtask

  initial begin
    test_reset;
    test_ideal;
    test_single_fault;
    test_start_in_check;
    test_reset_mid;
    test_start_with_reset;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dff_checker.md
# dff_checker

Synthesizable response checker for the flip-flop blocks. It watches the data input (`d_in`) and registered output (`q_in`) of a D flip-flop or short register pipeline and confirms that `q_in` reproduces `d_in` exactly LATENCY clocks later. It reports a pass/fail verdict, a saturating mismatch count and the index of the first mismatch. It sits beside the device under test in benches and on-chip self-test wrappers, as the observing end of a stimulus/response pair whose other end drives `d`.

## Interface

Parameters:
- LATENCY, 1, expected clock delay from `d_in` to `q_in`; legal range 1..15.
- NUM_CHECKS, 16, number of compared cycles per run; legal range 1..2^IW.
- CW, 8, width of the mismatch counter.
- IW, 8, width of the cycle index and first-error index.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- reset  input  1  synchronous, active-high reset; sampled on the rising edge of `clk`.
- start  input  1  single-cycle request to begin a run.
- d_in  input  1  DUT data input, as driven by the stimulus side.
- q_in  input  1  DUT output under check.
- busy  output  1  high in WARM and CHECK.
- done  output  1  high in DONE; holds until the next accepted `start` or `reset`.
- pass  output  1  `done` and zero mismatches.
- fail  output  1  `done` and one or more mismatches.
- err_count  output  CW  mismatches in the current or last run; saturates at 2^CW-1.
- err_seen  output  1  set on the first mismatch of a run.
- first_err_idx  output  IW  check index (0..NUM_CHECKS-1) of the first mismatch; valid only when `err_seen` is high.

## Operation

- Delay line: LATENCY-bit shift register. Bit 0 loads `d_in` on every edge in every state. `exp` is bit LATENCY-1, i.e. `d_in` sampled LATENCY edges earlier.
- FSM states: IDLE, WARM, CHECK, DONE.
  - IDLE: `start` moves to WARM.
  - WARM: stays exactly LATENCY cycles (warm counter loaded with LATENCY-1, counting down), then moves to CHECK.
  - CHECK: stays exactly NUM_CHECKS cycles, then moves to DONE.
  - DONE: `start` moves to WARM.
- Accepting `start` (in IDLE or DONE) clears `err_count`, `err_seen`, `first_err_idx`, `done`, `pass`, `fail` and the check index on the same edge.
- `start` is ignored while in WARM or CHECK.
- Each CHECK edge compares `q_in` against `exp`:
  - On mismatch, `err_count` increments, saturating at 2^CW-1.
  - On the first mismatch, `err_seen` is set to 1 and `first_err_idx` is loaded with the current check index.
  - Later mismatches leave `first_err_idx` unchanged.
- An X or Z value on `q_in` counts as a mismatch in simulation.
- `pass` and `fail` are registered and set on the edge that enters DONE. They are mutually exclusive.
- The delay line runs continuously, so `d_in` history from before `start` is flushed by WARM and never compared.

## Timing

- Reset: state = IDLE, delay line = 0, and every output is 0 (`busy`, `done`, `pass`, `fail`, `err_count`, `err_seen`, `first_err_idx`).
- Reset mid-run aborts to IDLE with all outputs 0. No verdict is produced.
- Reset has priority over `start` on the same edge.
- Edge numbering: E0 is the edge that samples `start`=1.
  - `busy` rises after E0.
  - WARM covers edges E1..E_L.
  - CHECK compares on edges E_{L+1}..E_{L+N} (N = NUM_CHECKS). The first compare uses the `d_in` sampled at E1.
  - `done`/`pass`/`fail` rise after E_{L+N}, and `busy` falls on the same edge.
- Latency from `start` to verdict: L+N+1 edges.
- A `start` in DONE begins a new run, with the same timing, on the next edge.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan

- Ideal DFF: LATENCY=1, N=16, period 10, `d_in` toggling every 10 time units, `q_in` = `d_in` registered. Required after 18 edges: `done`=1, `pass`=1, `fail`=0, `err_count`=0, `err_seen`=0.
- Single fault: the same setup with `q_in` forced inverted at check index 5 only. Required: `fail`=1, `err_count`=1, `err_seen`=1, `first_err_idx`=5.
- Latency mismatch: LATENCY=2 against a one-stage DFF, with `d_in` toggling every cycle. Required: every compare mismatches, `err_count`=16, `first_err_idx`=0.
- Saturation: CW=3, N=16, `q_in` stuck at ~`exp`. Required: `err_count`=7 at `done`, with no wrap.
- Reset and start handling:
  - `reset`=1 at E_{L+4}: required `busy`=0, `done`=0 and `err_count`=0 on the next cycle.
  - `start` pulsed during CHECK: ignored, and the verdict timing is unchanged.
  - `start` together with `reset`: the block stays in IDLE.
- Back-to-back runs: a failing run, then `start` in DONE with a clean DUT. Required: the counters clear on the `start` edge, and the second verdict is `pass`=1 after L+N+1 edges.
